// File: rtl/shift_reg_ctrl_if.sv
// Bundle between shift_reg_ctrl and the 8-bit universal shift register it drives,
// plus the request side (start, load data, shift parameters).
// The optional rot request bit exists only when SHIFT_REG_CTRL_ROTATE_EN is defined.
//
// Handshake: start is a level request sampled on the falling clock edge. It is
// accepted only while the controller is in IDLE or DONE; in LOAD and SHIFT it is
// ignored. busy is high while an accepted operation is in flight. done is a single
// cycle pulse marking completion. ser_out carries the bit leaving the register and
// is meaningful only while ser_valid is high.
interface shift_reg_ctrl_if;
    // Request side
    logic        start;
    logic [0:7]  din;
    logic        dir;
    logic [3:0]  count;
    logic        fill;
`ifdef SHIFT_REG_CTRL_ROTATE_EN
    logic        rot;
`endif
    // Register feedback
    logic [0:7]  sr_o;
    // Register control
    logic [0:1]  sr_s;
    logic [0:7]  sr_i;
    logic        sr_r;
    // Status and serial tap
    logic        busy;
    logic        done;
    logic        ser_out;
    logic        ser_valid;
    // FSM state for observation
    logic [1:0]  dbg_state;

    modport master (
        output start, din, dir, count, fill,
`ifdef SHIFT_REG_CTRL_ROTATE_EN
        output rot,
`endif
        output sr_o,
        input  sr_s, sr_i, sr_r, busy, done, ser_out, ser_valid, dbg_state
    );

    modport slave (
        input  start, din, dir, count, fill,
`ifdef SHIFT_REG_CTRL_ROTATE_EN
        input  rot,
`endif
        input  sr_o,
        output sr_s, sr_i, sr_r, busy, done, ser_out, ser_valid, dbg_state
    );
endinterface

// File: rtl/shift_reg_ctrl.sv
// Load-and-shift controller for an 8-bit universal shift register.
// One operation: load the latched byte (LOAD), shift it count times (SHIFT),
// then pulse done (DONE). All flops run on the falling clock edge, like the
// register being driven. Reset is asynchronous and active high.
// Optional feature: define SHIFT_REG_CTRL_ROTATE_EN to add the rot request bit,
// which feeds the outgoing bit back in as the serial input so the byte rotates.
module shift_reg_ctrl (
    input logic             clk,
    input logic             reset,
    shift_reg_ctrl_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0] state_q, state_d;
    logic [0:7] din_q,   din_d;
    logic       dir_q,   dir_d;
    logic       fill_q,  fill_d;
    logic [3:0] cnt_q,   cnt_d;
`ifdef SHIFT_REG_CTRL_ROTATE_EN
    logic       rot_q,   rot_d;
`endif

    logic accept;
    logic ser_bit;

    // A new request is taken only between operations.
    assign accept = bus.start && ((state_q == IDLE) || (state_q == DONE));

    // Next-state, down-counter and request latching.
    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        dir_d   = dir_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
`ifdef SHIFT_REG_CTRL_ROTATE_EN
        rot_d   = rot_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = (cnt_q == 4'd0) ? DONE : SHIFT;
            end
            SHIFT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = bus.start ? LOAD : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // The counter doubles as the latched count; counts above 8 collapse to a full byte.
        if (accept) begin
            din_d  = bus.din;
            dir_d  = bus.dir;
            fill_d = bus.fill;
            cnt_d  = (bus.count > 4'd8) ? 4'd8 : bus.count;
`ifdef SHIFT_REG_CTRL_ROTATE_EN
            rot_d  = bus.rot;
`endif
        end
    end

    // Falling-edge state register with asynchronous clear.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            din_q   <= '0;
            dir_q   <= 1'b0;
            fill_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SHIFT_REG_CTRL_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            dir_q   <= dir_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
`ifdef SHIFT_REG_CTRL_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    // Register mode select decoded from state and latched direction.
    always_comb begin
        bus.sr_s = 2'b00;
        case (state_q)
            LOAD:    bus.sr_s = 2'b11;
            SHIFT:   bus.sr_s = dir_q ? 2'b10 : 2'b01;
            default: bus.sr_s = 2'b00;
        endcase
    end

    // Outgoing bit is the end the register shifts away from; forced low while reset
    // is held so every output reads zero immediately, whatever the register holds.
    assign ser_bit       = reset ? 1'b0 : (dir_q ? bus.sr_o[0] : bus.sr_o[7]);
    assign bus.ser_out   = ser_bit;
    assign bus.ser_valid = (state_q == SHIFT);

    // Parallel data always presents the latched byte so the LOAD edge captures it.
    assign bus.sr_i = din_q;

`ifdef SHIFT_REG_CTRL_ROTATE_EN
    // Rotating recirculates the outgoing bit; otherwise the latched fill bit enters.
    assign bus.sr_r = (rot_q && (state_q == SHIFT)) ? ser_bit : fill_q;
`else
    assign bus.sr_r = fill_q;
`endif

    assign bus.busy      = (state_q == LOAD) || (state_q == SHIFT);
    assign bus.done      = (state_q == DONE);
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Bench for shift_reg_ctrl: a behavioural 8-bit universal shift register closes
// the sr_* loop. Expected serial bits and final register contents are queued when
// an operation is issued and compared when the DUT produces them.
module tb_shift_reg_ctrl;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  logic clk = 1'b0;
  logic reset;
  logic [0:7] sr_q = '0;

  shift_reg_ctrl_if bus ();

  shift_reg_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driven register: same mode encoding, updates on the falling edge.
  always @(negedge clk) begin
    case (bus.sr_s)
      2'b11:   sr_q <= bus.sr_i;
      2'b01:   sr_q <= {bus.sr_r, sr_q[0:6]};
      2'b10:   sr_q <= {sr_q[1:7], bus.sr_r};
      default: sr_q <= sr_q;
    endcase
  end
  assign bus.sr_o = sr_q;

  // Scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_ser_q[$];
  logic [7:0] exp_fin_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference shifting of the requested byte, producing the outgoing bit stream.
  task automatic push_expect(input logic [0:7] d, input logic dr, input int n,
                             input logic f, input logic rt);
    logic [0:7] r;
    logic b;
    logic in_bit;
    r = d;
    for (int i = 0; i < n; i++) begin
      b = dr ? r[0] : r[7];
      exp_ser_q.push_back(b);
      in_bit = rt ? b : f;
      r = dr ? {r[1:7], in_bit} : {in_bit, r[0:6]};
    end
  endtask

  // Monitor on the rising edge, away from the falling active edge.
  always @(posedge clk) begin
    if (!reset) begin
      if (bus.ser_valid) begin
        if (exp_ser_q.size() == 0) check("ser_unexpected", 1, 0);
        else check("ser_out", bus.ser_out, exp_ser_q.pop_front());
      end
      if (bus.done) begin
        check("done_sr_s", bus.sr_s, 2'b00);
        if (exp_fin_q.size() == 0) check("done_unexpected", 1, 0);
        else check("final_sr_o", sr_q, exp_fin_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic drive_req(input logic [0:7] d, input logic dr, input logic [3:0] c,
                           input logic f, input logic rt);
    bus.start = 1'b1;
    bus.din   = d;
    bus.dir   = dr;
    bus.count = c;
    bus.fill  = f;
`ifdef SHIFT_REG_CTRL_ROTATE_EN
    bus.rot   = rt;
`endif
  endtask

  task automatic run_op(input logic [0:7] d, input logic dr, input logic [3:0] c,
                        input logic f, input logic rt, input logic [0:7] exp_final,
                        input string tag);
    int n;
    int k;
    int busy_cyc;
    n = (c > 4'd8) ? 8 : int'(c);
    push_expect(d, dr, n, f, rt);
    exp_fin_q.push_back(exp_final);
    @(posedge clk);
    drive_req(d, dr, c, f, rt);
    @(posedge clk);
    bus.start = 1'b0;
    check({tag, "_load_sr_s"}, bus.sr_s, 2'b11);
    k = 1;
    busy_cyc = 0;
    while (!bus.done && k < 40) begin
      if (bus.busy) busy_cyc++;
      @(posedge clk);
      k++;
    end
    check({tag, "_latency"}, k - 1, n + 1);
    check({tag, "_busy_cycles"}, busy_cyc, n + 1);
    @(posedge clk);
    check({tag, "_done_cleared"}, bus.done, 1'b0);
    check({tag, "_back_to_idle"}, bus.dbg_state, ST_IDLE);
  endtask

  typedef struct {
    logic [0:7] din;
    logic       dir;
    logic [3:0] count;
    logic       fill;
    logic [0:7] exp_final;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int t;
    logic [8:0] done_mask;

    vecs[0] = '{8'b10110001, 1'b0, 4'd3,  1'b0, 8'b00010110};
    vecs[1] = '{8'b10110001, 1'b1, 4'd8,  1'b1, 8'b11111111};
    vecs[2] = '{8'b10110001, 1'b0, 4'd0,  1'b1, 8'b10110001};
    vecs[3] = '{8'b11001010, 1'b0, 4'd12, 1'b0, 8'b00000000};
    vecs[4] = '{8'b11110000, 1'b1, 4'd2,  1'b1, 8'b11000011};
    vecs[5] = '{8'b00000001, 1'b0, 4'd1,  1'b1, 8'b10000000};
    vecs[6] = '{8'b01010101, 1'b1, 4'd15, 1'b0, 8'b00000000};
    vecs[7] = '{8'b10011001, 1'b0, 4'd5,  1'b1, 8'b11111100};

    bus.start = 1'b0;
    bus.din   = '0;
    bus.dir   = 1'b0;
    bus.count = '0;
    bus.fill  = 1'b0;
`ifdef SHIFT_REG_CTRL_ROTATE_EN
    bus.rot   = 1'b0;
`endif

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    check("rst_sr_s", bus.sr_s, 2'b00);
    check("rst_sr_i", bus.sr_i, 8'h00);
    check("rst_sr_r", bus.sr_r, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_ser_out", bus.ser_out, 1'b0);
    check("rst_ser_valid", bus.ser_valid, 1'b0);
    check("rst_state", bus.dbg_state, ST_IDLE);
    reset = 1'b0;

    // Table-driven operations
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].din, vecs[i].dir, vecs[i].count, vecs[i].fill, 1'b0,
             vecs[i].exp_final, $sformatf("vec%0d", i));
    end

    // Reset in the middle of SHIFT: everything drops, no done, restart works
    push_expect(8'b10110001, 1'b0, 8, 1'b0, 1'b0);
    exp_fin_q.push_back(8'h00);
    @(posedge clk);
    drive_req(8'b10110001, 1'b0, 4'd8, 1'b0, 1'b0);
    @(posedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    check("mid_pre_state", bus.dbg_state, ST_SHIFT);
    #2 reset = 1'b1;
    #1;
    check("mid_sr_s", bus.sr_s, 2'b00);
    check("mid_sr_i", bus.sr_i, 8'h00);
    check("mid_sr_r", bus.sr_r, 1'b0);
    check("mid_busy", bus.busy, 1'b0);
    check("mid_done", bus.done, 1'b0);
    check("mid_ser_out", bus.ser_out, 1'b0);
    check("mid_ser_valid", bus.ser_valid, 1'b0);
    exp_ser_q.delete();
    exp_fin_q.delete();
    repeat (2) @(posedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      check("post_rst_no_done", bus.done, 1'b0);
      check("post_rst_idle", bus.dbg_state, ST_IDLE);
    end
    run_op(8'b10110001, 1'b0, 4'd3, 1'b0, 1'b0, 8'b00010110, "after_rst");

    // start held high: DONE goes straight to LOAD, held start in SHIFT is ignored
    push_expect(8'b00111100, 1'b0, 2, 1'b1, 1'b0);
    push_expect(8'b00111100, 1'b0, 2, 1'b1, 1'b0);
    exp_fin_q.push_back(8'b11001111);
    exp_fin_q.push_back(8'b11001111);
    done_mask = '0;
    @(posedge clk);
    drive_req(8'b00111100, 1'b0, 4'd2, 1'b1, 1'b0);
    for (int s = 1; s <= 8; s++) begin
      @(posedge clk);
      if (bus.done) done_mask[s] = 1'b1;
      if (s == 5) begin
        check("b2b_reload_state", bus.dbg_state, ST_LOAD);
        check("b2b_reload_busy", bus.busy, 1'b1);
      end
    end
    bus.start = 1'b0;
    check("b2b_done_positions", done_mask, 9'h110);
    @(posedge clk);
    check("b2b_idle", bus.dbg_state, ST_IDLE);

    // A start pulse with different data during SHIFT changes nothing
    push_expect(8'b10010110, 1'b1, 4, 1'b0, 1'b0);
    exp_fin_q.push_back(8'b01100000);
    @(posedge clk);
    drive_req(8'b10010110, 1'b1, 4'd4, 1'b0, 1'b0);
    @(posedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    check("ign_in_shift", bus.dbg_state, ST_SHIFT);
    drive_req(8'hFF, 1'b0, 4'd1, 1'b1, 1'b0);
    @(posedge clk);
    bus.start = 1'b0;
    t = 3;
    while (!bus.done && t < 40) begin
      @(posedge clk);
      t++;
    end
    check("ign_done_cycle", t, 6);
    @(posedge clk);
    check("ign_done_once", bus.done, 1'b0);
    check("ign_idle", bus.dbg_state, ST_IDLE);

`ifdef SHIFT_REG_CTRL_ROTATE_EN
    // Full rotation returns the original byte
    run_op(8'b10000001, 1'b0, 4'd8, 1'b0, 1'b1, 8'b10000001, "rotate");
    run_op(8'b11010010, 1'b1, 4'd3, 1'b0, 1'b1, 8'b10010110, "rotate3");
`endif

    repeat (2) @(posedge clk);
    check("ser_queue_drained", exp_ser_q.size(), 0);
    check("fin_queue_drained", exp_fin_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
